aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Iterative AES-128 key schedule. It accepts a 128-bit cipher key, produces one round key per clock, and holds all 11 round keys in an internal register file. It sits directly upstream of the encryption and decryption cores in the wrapper:
- The encryptor reads keys in index order 0→10.
- The decryptor reads keys in reverse order 10→0 through the same random-access port.

## Interface
Parameters: none (AES-128 only; Nk=4, Nr=10 fixed).

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request; samples key_in and begins expansion
- key_in  in  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0]
- rd_idx  in  4  round-key index to read, 0..10
- rd_key  out  128  round key rk[rd_idx], combinational read; 128'h0 when rd_idx > 10
- busy  out  1  high while expanding
- keys_valid  out  1  high when rk[0..10] all correspond to the last accepted key
- done  out  1  one-cycle pulse when expansion completes

Clock/reset: one clock; reset is asynchronous and active-high (ports clk, reset).

## Operation
- States:
  - IDLE: after reset.
  - EXPAND: 10 generation cycles.
  - READY: keys held.
- Transitions:
  - IDLE or READY, start=1 → EXPAND. Actions: rk[0] ← key_in, round counter ← 1, rcon ← 8'h01, keys_valid ← 0.
  - EXPAND: start is ignored. Each cycle writes rk[cnt] from rk[cnt-1], advances the counter and updates rcon.
  - EXPAND, write of rk[10] → READY. keys_valid ← 1, done pulses for one cycle.
  - READY with no start: hold. rk contents are stable indefinitely.
- Round-key generation, with previous key words p0..p3:
  - t = SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES S-box to each byte.
  - n0 = p0^t, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2.
  - New key = {n0,n1,n2,n3}.
- rcon update is xtime: rcon ← {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Sequence: 01,02,04,08,10,20,40,80,1b,36.
- S-box: four combinational lookups per cycle, implemented in-block (256-entry case/function). No memories.
- rd_key is valid for any stored entry at any time. Consumers must gate their use on keys_valid.
- During EXPAND, entries not yet rewritten hold stale values from the previous key.

## Timing
- Reset values: busy=0, keys_valid=0, done=0, state=IDLE, counter=0, rcon=0, all rk[i]=0. rd_key therefore reads 0.
- start sampled high at edge E0:
  - rk[0] is written at E0, and busy=1 after E0.
  - rk[i] is written at edge Ei, for i=1..10.
  - After E10: busy=0, keys_valid=1, done=1. done falls after E11.
- Latency is 10 cycles from the start edge to keys_valid.
- The next start is accepted the cycle after E10, i.e. while done=1 in READY.
- Simultaneous start with the E10 completion edge: start is ignored, because the state is still EXPAND.
- Reset asserted mid-EXPAND: all state clears immediately (asynchronous). A partially written key table is not retained.
- rd_key has no added latency: an index change is reflected in the same cycle.

## Test plan
- **Reset:** assert reset, then release. Required: busy=0, keys_valid=0, done=0, and rd_key=0 for rd_idx 0..15.
- **FIPS-197 vector:** key_in=2b7e151628aed2a6abf7158809cf4f3c with a start pulse. Required:
  - keys_valid and done rise exactly 10 cycles after the start edge, and done lasts one cycle.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk[0]=key_in.
- **Zero key:** key_in=0 with start. Required: rk[1]=62636363626363636263636362636363 and rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- **Start during EXPAND:** pulse start with a different key at cycle 5 of expansion. Required: ignored, and the final rk[10] matches the first key's schedule.
- **Reset mid-EXPAND:** assert reset at cycle 4 of expansion. Required: outputs and table go to 0 immediately. A later start with the FIPS key then gives the correct rk[10].
- **Restart from READY, then read-out:** after the FIPS key completes, start with the zero key. Required:
  - keys_valid drops the cycle after start and rises 10 cycles later with the zero-key schedule.
  - Sweeping rd_idx 10→0 returns the keys in reverse order.
  - rd_idx 11..15 returns 0.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES-128 key schedule, one round key per clock.
// Holds all eleven round keys in a register table with a combinational read port.
// The encryptor reads this table forward and the decryptor reads it in reverse.
module aes_key_expander (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         keys_valid,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  // AES S-box, entry 0 first (packed ascending so SBOX[x] is entry x)
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  state_t       state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic         keys_valid_reg, keys_valid_next;
  logic         done_reg, done_next;
  logic         accept;
  logic         gen_en;
  logic [127:0] rk_q [0:10];
  logic [127:0] prev_key;
  logic [127:0] new_key;
  logic [31:0]  p0, p1, p2, p3, rot_w, t_w, n0, n1, n2, n3;

  // Control registers: state, round counter, rcon and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      rcon_reg       <= 8'h00;
      keys_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rcon_reg       <= rcon_next;
      keys_valid_reg <= keys_valid_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic; start is only honoured outside EXPAND
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    rcon_next       = rcon_reg;
    keys_valid_next = keys_valid_reg;
    done_next       = 1'b0;
    accept          = 1'b0;
    gen_en          = 1'b0;
    case (state_reg)
      IDLE, READY: begin
        if (start) begin
          accept          = 1'b1;
          state_next      = EXPAND;
          cnt_next        = 4'd1;
          rcon_next       = 8'h01;
          keys_valid_next = 1'b0;
        end
      end
      EXPAND: begin
        gen_en    = 1'b1;
        rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
        if (cnt_reg == 4'd10) begin
          // Last round key written this edge; counter parks at 10
          state_next      = READY;
          keys_valid_next = 1'b1;
          done_next       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the previous round key rk[cnt-1] as the generation source
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++) begin
      if (cnt_reg == 4'(i + 1)) prev_key = rk_q[i];
    end
  end

  // One round of the key schedule from the previous key and current rcon
  always_comb begin
    p0    = prev_key[127:96];
    p1    = prev_key[95:64];
    p2    = prev_key[63:32];
    p3    = prev_key[31:0];
    rot_w = {p3[23:0], p3[31:24]};
    t_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
            ^ {rcon_reg, 24'h0};
    n0    = p0 ^ t_w;
    n1    = p1 ^ n0;
    n2    = p2 ^ n1;
    n3    = p3 ^ n2;
    new_key = {n0, n1, n2, n3};
  end

  // Round-key table: entry 0 loads the cipher key, entry i loads round i
  generate
    for (genvar gi = 0; gi < 11; gi++) begin : g_rk
      logic [127:0] key_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          key_reg <= '0;
        end else if (accept && (gi == 0)) begin
          key_reg <= key_in;
        end else if (gen_en && (cnt_reg == 4'(gi))) begin
          key_reg <= new_key;
        end
      end
      assign rk_q[gi] = key_reg;
    end
  endgenerate

  // Combinational read port; indices above 10 read as zero
  always_comb begin
    rd_key = '0;
    for (int i = 0; i < 11; i++) begin
      if (rd_idx == 4'(i)) rd_key = rk_q[i];
    end
  end

  assign busy       = (state_reg == EXPAND);
  assign keys_valid = keys_valid_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander.
// Expected round keys come from an independent schedule model whose S-box is
// derived from GF(2^8) inversion plus the affine map, and from published vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;
  logic         keys_valid;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  logic [127:0] exp_q [$];
  logic [7:0]   sbox_m [256];
  logic [7:0]   rc_tab [10];
  logic [127:0] fips_sched [11];
  logic [127:0] zero_sched [11];

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expander dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard read: expectation queued with the index, compared once settled
  task automatic read_key(input string tag, input int idx, input logic [127:0] expv);
    rd_idx = 4'(idx);
    exp_q.push_back(expv);
    #1;
    check($sformatf("%s rk[%0d]", tag, idx), rd_key, exp_q.pop_front());
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_next(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] t;
    w[0] = prev[127:96];
    w[1] = prev[95:64];
    w[2] = prev[63:32];
    w[3] = prev[31:0];
    t = subw({w[3][23:0], w[3][31:24]}) ^ {rc, 24'h0};
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    fips_sched[0] = FIPS_KEY;
    zero_sched[0] = '0;
    for (int r = 1; r < 11; r++) begin
      fips_sched[r] = model_next(fips_sched[r-1], rc_tab[r-1]);
      zero_sched[r] = model_next(zero_sched[r-1], rc_tab[r-1]);
    end
  endtask

  // Start pulse then check flag timing edge by edge through E11
  task automatic run_expansion(input string tag, input logic [127:0] key);
    start  = 1'b1;
    key_in = key;
    tick();
    start = 1'b0;
    check({tag, " busy@E0"}, 128'(busy), 128'd1);
    check({tag, " kv@E0"}, 128'(keys_valid), 128'd0);
    repeat (9) tick();
    check({tag, " kv@E9"}, 128'(keys_valid), 128'd0);
    check({tag, " done@E9"}, 128'(done), 128'd0);
    tick();
    check({tag, " kv@E10"}, 128'(keys_valid), 128'd1);
    check({tag, " done@E10"}, 128'(done), 128'd1);
    check({tag, " busy@E10"}, 128'(busy), 128'd0);
    tick();
    check({tag, " done@E11"}, 128'(done), 128'd0);
    check({tag, " kv@E11"}, 128'(keys_valid), 128'd1);
  endtask

  initial begin
    build_model();
    reset  = 1'b1;
    start  = 1'b0;
    key_in = '0;
    rd_idx = 4'd0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset busy", 128'(busy), 128'd0);
    check("reset kv", 128'(keys_valid), 128'd0);
    check("reset done", 128'(done), 128'd0);
    for (int i = 0; i < 16; i++) read_key("reset", i, '0);

    // FIPS-197 vector
    run_expansion("fips", FIPS_KEY);
    read_key("fips const", 0, FIPS_KEY);
    read_key("fips const", 1, FIPS_RK1);
    read_key("fips const", 10, FIPS_RK10);
    for (int i = 0; i < 11; i++) read_key("fips model", i, fips_sched[i]);

    // Restart from READY with the zero key, then reverse read-out
    tick();
    run_expansion("zero", '0);
    read_key("zero const", 1, ZERO_RK1);
    read_key("zero const", 10, ZERO_RK10);
    for (int i = 10; i >= 0; i--) read_key("zero rev", i, zero_sched[i]);
    for (int i = 11; i < 16; i++) read_key("zero oob", i, '0);

    // Start during EXPAND (cycle 5) and coincident with the E10 edge: both ignored
    tick();
    start  = 1'b1;
    key_in = FIPS_KEY;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start  = 1'b1;
    key_in = '0;
    tick();
    start = 1'b0;
    check("midstart busy", 128'(busy), 128'd1);
    repeat (4) tick();
    start  = 1'b1;
    key_in = '0;
    tick();
    start = 1'b0;
    check("midstart kv@E10", 128'(keys_valid), 128'd1);
    check("midstart done@E10", 128'(done), 128'd1);
    tick();
    check("e10start busy@E11", 128'(busy), 128'd0);
    check("e10start kv@E11", 128'(keys_valid), 128'd1);
    read_key("midstart", 0, FIPS_KEY);
    read_key("midstart", 10, FIPS_RK10);
    read_key("midstart", 5, fips_sched[5]);

    // Reset at cycle 4 of expansion clears everything immediately
    tick();
    start  = 1'b1;
    key_in = '0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("midreset busy", 128'(busy), 128'd0);
    check("midreset kv", 128'(keys_valid), 128'd0);
    check("midreset done", 128'(done), 128'd0);
    for (int i = 0; i < 11; i++) read_key("midreset", i, '0);
    tick();
    reset = 1'b0;
    tick();
    run_expansion("postreset", FIPS_KEY);
    read_key("postreset", 10, FIPS_RK10);
    read_key("postreset", 1, FIPS_RK1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
